sram_rr_arbiter: RTL and testbench
==================================

# sram_rr_arbiter

Sequencing arbiter that shares the board's single asynchronous 16-bit SRAM between the SOPC conduit master and the test-runner master. It handles arbitration, SRAM pin timing and read-data return, replacing the hard select-based mux. Round-robin is the default arbitration mode. A priority mode, used while a test run is active, favours the test runner but caps consecutive test-runner grants so the SOPC side cannot starve.

## Interface
Parameters:
- ADDR_WIDTH, 20, SRAM word-address width
- DATA_WIDTH, 16, SRAM data width; byteenable is DATA_WIDTH/8 bits
- ACCESS_CYCLES, 2, cycles the SRAM strobes are held active per access; legal range is 1 or more
- STARVE_LIMIT, 4, maximum consecutive test-runner grants while SOPC waits in priority mode; legal range is 1 or more

Ports (one clock; reset is asynchronous and active-high):
- clock, in, 1, system clock (clock_100 domain)
- reset, in, 1, asynchronous active-high reset
- tr_priority, in, 1, 1 selects priority mode; 0 selects round-robin
- sopc_address / tr_address, in, ADDR_WIDTH, word address
- sopc_byteenable / tr_byteenable, in, DATA_WIDTH/8, active-high byte lanes
- sopc_read / tr_read, in, 1, read request
- sopc_write / tr_write, in, 1, write request
- sopc_writedata / tr_writedata, in, DATA_WIDTH, write data
- sopc_waitrequest / tr_waitrequest, out, 1, low for exactly the acceptance cycle
- sopc_readdata / tr_readdata, out, DATA_WIDTH, registered read data
- sopc_readdataready / tr_readdataready, out, 1, one-cycle read-data-valid pulse
- sram_address, out, ADDR_WIDTH, SRAM address
- sram_data, inout, DATA_WIDTH, SRAM data bus
- sram_ce_n / sram_oe_n / sram_we_n, out, 1, SRAM strobes (active-low)
- sram_be_n, out, DATA_WIDTH/8, SRAM byte enables (active-low)
- busy, out, 1, high in any state other than IDLE

## Operation
- FSM states and transitions:
  - IDLE: pick a winner → ACCESS.
  - ACCESS: hold for ACCESS_CYCLES → RECOVER.
  - RECOVER: 1 cycle → IDLE.
- Request rules:
  - A request is read | write, held by the master until its waitrequest is seen low.
  - If a master asserts read and write together, it is treated as a write.
- Acceptance in IDLE with at least one request:
  - The winner's waitrequest goes low combinationally in that cycle.
  - The winner's address, byteenable, writedata and direction are captured at the clock edge.
- Waitrequest is high in all other cycles, for both masters.
- Round-robin mode (tr_priority=0):
  - If only one master requests, it wins.
  - If both request, the master not granted last wins.
- Priority mode (tr_priority=1):
  - tr wins over sopc, unless starve_cnt == STARVE_LIMIT and sopc is requesting, in which case sopc wins.
- starve_cnt update at each grant:
  - +1 on a tr grant while sopc is also requesting.
  - Cleared on an sopc grant, or on a tr grant with sopc idle.
  - Saturates at STARVE_LIMIT.
  - Updated in both modes; consulted only in priority mode.
- last_grant updates on every grant. Its reset value is tr, so SOPC wins the first contention.
- ACCESS pin behaviour:
  - sram_ce_n=0 and sram_be_n=~byteenable.
  - Read: sram_oe_n=0, sram_data is Z.
  - Write: sram_we_n=0, sram_data driven with captured data.
- Read data:
  - sram_data is sampled at the clock edge ending the last ACCESS cycle.
  - The sampled data goes to the owner's readdata register; the other master's readdata holds its old value.
- RECOVER:
  - All strobes high and be_n all-ones.
  - On a write, sram_data stays driven (hold time); on a read it is Z.
  - The owner's readdataready is high for this cycle, for reads only.
- sram_address holds its last value outside ACCESS.

## Timing
- Reset values: ce_n, oe_n and we_n = 1; be_n = all-ones; sram_address = 0; sram_data = Z; both readdata = 0; both readdataready = 0; busy = 0; FSM in IDLE; starve_cnt = 0.
- Reset mid-transaction: all outputs take their reset values immediately. No readdataready pulse is issued for the aborted read. The master must reissue the request.
- Transaction cost: 1 (IDLE) + ACCESS_CYCLES + 1 (RECOVER) cycles. The next acceptance is possible at the IDLE cycle that follows.
- Read latency: readdataready is asserted ACCESS_CYCLES+1 cycles after the acceptance cycle.
- Throughput: back-to-back requests from one master get one grant per ACCESS_CYCLES+2 cycles.
- A new request arriving in ACCESS or RECOVER sees waitrequest high; it is arbitrated at the next IDLE.
- A change of tr_priority takes effect at the next IDLE decision.
- The strobes and sram_address are registered outputs (no glitches). waitrequest is combinational from state and requests.

## Test plan
- Single read, ACCESS_CYCLES=2: sopc reads 0x00010 with the SRAM model returning 0xBEEF → waitrequest low at t0; ce_n/oe_n low at t1–t2; sopc_readdataready pulse at t3 with data 0xBEEF; tr outputs unchanged.
- Single write: tr writes 0xA5A5 to 0xFFFFF with be=2'b01 → we_n low for 2 cycles, be_n=2'b10, data held through RECOVER; a following read of 0xFFFFF returns 0x??A5 with the low byte updated.
- Round-robin: both masters issue continuous reads with tr_priority=0 → grants alternate sopc, tr, sopc, tr; each grant comes 4 cycles after the previous one.
- Priority mode with starvation cap: tr_priority=1, STARVE_LIMIT=4, both masters continuous → grant pattern tr×4, sopc, tr×4, sopc, …
- Reset mid-read: assert reset during the second ACCESS cycle → strobes go high and sram_data goes Z within that cycle; no readdataready pulse; the first request after reset is accepted normally.
- Write+read on same master, plus a late arrival: sopc asserts read and write together → handled as a write; a tr request arriving during ACCESS waits and is accepted at the next IDLE.

Source files
------------

// File: rtl/sram_rr_arbiter.sv
// Shares one asynchronous SRAM between the SOPC and test-runner masters.
// Round-robin or capped-priority arbitration, registered pin timing, registered read return.
module sram_rr_arbiter #(
  parameter int ADDR_WIDTH    = 20,
  parameter int DATA_WIDTH    = 16,
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      tr_priority,
  input  logic [ADDR_WIDTH-1:0]     sopc_address,
  input  logic [DATA_WIDTH/8-1:0]   sopc_byteenable,
  input  logic                      sopc_read,
  input  logic                      sopc_write,
  input  logic [DATA_WIDTH-1:0]     sopc_writedata,
  output logic                      sopc_waitrequest,
  output logic [DATA_WIDTH-1:0]     sopc_readdata,
  output logic                      sopc_readdataready,
  input  logic [ADDR_WIDTH-1:0]     tr_address,
  input  logic [DATA_WIDTH/8-1:0]   tr_byteenable,
  input  logic                      tr_read,
  input  logic                      tr_write,
  input  logic [DATA_WIDTH-1:0]     tr_writedata,
  output logic                      tr_waitrequest,
  output logic [DATA_WIDTH-1:0]     tr_readdata,
  output logic                      tr_readdataready,
  output logic [ADDR_WIDTH-1:0]     sram_address,
  inout  wire  [DATA_WIDTH-1:0]     sram_data,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n,
  output logic [DATA_WIDTH/8-1:0]   sram_be_n,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(ACCESS_CYCLES - 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  last_tr_q, last_tr_d;
  logic                  owner_tr_q, owner_tr_d;
  logic                  is_write_q, is_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ce_n_q, ce_n_d;
  logic                  oe_n_q, oe_n_d;
  logic                  we_n_q, we_n_d;
  logic [BW-1:0]         be_n_q, be_n_d;
  logic                  data_oe_q, data_oe_d;
  logic [DATA_WIDTH-1:0] sopc_rdata_q, sopc_rdata_d;
  logic [DATA_WIDTH-1:0] tr_rdata_q, tr_rdata_d;
  logic                  sopc_rdy_q, sopc_rdy_d;
  logic                  tr_rdy_q, tr_rdy_d;

  logic                  sopc_req, tr_req;
  logic                  grant_sopc, grant_tr;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [BW-1:0]         sel_be;

  assign sopc_req = sopc_read | sopc_write;
  assign tr_req   = tr_read | tr_write;

  // Winner selection is only meaningful in IDLE; the starve cap overrides tr priority.
  always_comb begin
    grant_sopc = 1'b0;
    grant_tr   = 1'b0;
    if (state_q == IDLE) begin
      if (tr_priority) begin
        if (tr_req && !(sopc_req && starve_q == STARVE_MAX)) grant_tr = 1'b1;
        else if (sopc_req)                                   grant_sopc = 1'b1;
      end else if (tr_req && sopc_req) begin
        grant_tr   = ~last_tr_q;
        grant_sopc = last_tr_q;
      end else begin
        grant_tr   = tr_req;
        grant_sopc = sopc_req;
      end
    end
  end

  assign sopc_waitrequest = ~grant_sopc;
  assign tr_waitrequest   = ~grant_tr;

  assign sel_write = grant_tr ? tr_write       : sopc_write;
  assign sel_addr  = grant_tr ? tr_address     : sopc_address;
  assign sel_wdata = grant_tr ? tr_writedata   : sopc_writedata;
  assign sel_be    = grant_tr ? tr_byteenable  : sopc_byteenable;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    last_tr_d    = last_tr_q;
    owner_tr_d   = owner_tr_q;
    is_write_d   = is_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    ce_n_d       = ce_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
    be_n_d       = be_n_q;
    data_oe_d    = data_oe_q;
    sopc_rdata_d = sopc_rdata_q;
    tr_rdata_d   = tr_rdata_q;
    sopc_rdy_d   = 1'b0;
    tr_rdy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_sopc || grant_tr) begin
          state_d    = ACCESS;
          cnt_d      = '0;
          owner_tr_d = grant_tr;
          last_tr_d  = grant_tr;
          is_write_d = sel_write;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          ce_n_d     = 1'b0;
          oe_n_d     = sel_write;
          we_n_d     = ~sel_write;
          be_n_d     = ~sel_be;
          data_oe_d  = sel_write;
          // Starve count tracks tr grants won while sopc was left waiting.
          if (grant_sopc || !sopc_req) starve_d = '0;
          else if (starve_q != STARVE_MAX) starve_d = starve_q + 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = RECOVER;
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          be_n_d  = '1;
          if (!is_write_q) begin
            if (owner_tr_q) begin
              tr_rdata_d = sram_data;
              tr_rdy_d   = 1'b1;
            end else begin
              sopc_rdata_d = sram_data;
              sopc_rdy_d   = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      starve_q     <= '0;
      last_tr_q    <= 1'b1;
      owner_tr_q   <= 1'b0;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      be_n_q       <= '1;
      data_oe_q    <= 1'b0;
      sopc_rdata_q <= '0;
      tr_rdata_q   <= '0;
      sopc_rdy_q   <= 1'b0;
      tr_rdy_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      last_tr_q    <= last_tr_d;
      owner_tr_q   <= owner_tr_d;
      is_write_q   <= is_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      be_n_q       <= be_n_d;
      data_oe_q    <= data_oe_d;
      sopc_rdata_q <= sopc_rdata_d;
      tr_rdata_q   <= tr_rdata_d;
      sopc_rdy_q   <= sopc_rdy_d;
      tr_rdy_q     <= tr_rdy_d;
    end
  end

  // Write data stays on the bus through RECOVER for SRAM hold time.
  assign sram_data          = data_oe_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign sram_address       = addr_q;
  assign sram_ce_n          = ce_n_q;
  assign sram_oe_n          = oe_n_q;
  assign sram_we_n          = we_n_q;
  assign sram_be_n          = be_n_q;
  assign sopc_readdata      = sopc_rdata_q;
  assign tr_readdata        = tr_rdata_q;
  assign sopc_readdataready = sopc_rdy_q;
  assign tr_readdataready   = tr_rdy_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: behavioural SRAM, reference memory and read-data scoreboard.
// The SRAM model decodes only the low 8 address bits; test addresses are distinct there.
module tb_sram_rr_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        tr_priority;
  logic [19:0] sopc_address, tr_address;
  logic [1:0]  sopc_byteenable, tr_byteenable;
  logic        sopc_read, sopc_write, tr_read, tr_write;
  logic [15:0] sopc_writedata, tr_writedata;
  logic        sopc_waitrequest, tr_waitrequest;
  logic [15:0] sopc_readdata, tr_readdata;
  logic        sopc_readdataready, tr_readdataready;
  logic [19:0] sram_address;
  wire  [15:0] sram_data;
  logic        sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]  sram_be_n;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  logic        mem_loaded = 1'b0;
  logic        ref_loaded = 1'b0;

  logic [15:0] sopc_q[$], tr_q[$];
  int          sopc_cyc[$], tr_cyc[$];
  bit          log_en = 1'b0;
  int          grant_who[$], grant_cyc[$], exp_grant[$];

  sram_rr_arbiter #(
    .ADDR_WIDTH(20), .DATA_WIDTH(16), .ACCESS_CYCLES(2), .STARVE_LIMIT(4)
  ) dut (
    .clock(clock), .reset(reset), .tr_priority(tr_priority),
    .sopc_address(sopc_address), .sopc_byteenable(sopc_byteenable),
    .sopc_read(sopc_read), .sopc_write(sopc_write), .sopc_writedata(sopc_writedata),
    .sopc_waitrequest(sopc_waitrequest), .sopc_readdata(sopc_readdata),
    .sopc_readdataready(sopc_readdataready),
    .tr_address(tr_address), .tr_byteenable(tr_byteenable),
    .tr_read(tr_read), .tr_write(tr_write), .tr_writedata(tr_writedata),
    .tr_waitrequest(tr_waitrequest), .tr_readdata(tr_readdata),
    .tr_readdataready(tr_readdataready),
    .sram_address(sram_address), .sram_data(sram_data),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_be_n(sram_be_n), .busy(busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic logic [15:0] initWord(input int i);
    if (i == 8'h10) return 16'hBEEF;
    if (i == 8'hFF) return 16'h3C3C;
    return 16'h5A00 ^ 16'(i);
  endfunction

  // Asynchronous SRAM: combinational read while ce_n/oe_n low, byte-lane writes while we_n low.
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_address[7:0]] : 16'hzzzz;

  always @(posedge clock) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= initWord(i);
      mem_loaded <= 1'b1;
    end else if (!sram_ce_n && !sram_we_n) begin
      if (!sram_be_n[0]) mem[sram_address[7:0]][7:0]  <= sram_data[7:0];
      if (!sram_be_n[1]) mem[sram_address[7:0]][15:8] <= sram_data[15:8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mergeWrite(input logic [15:0] old, input logic [15:0] d,
                                             input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[0]) r[7:0]  = d[7:0];
    if (be[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  // Acceptance pushes the expected read word; the readdataready pulse pops and compares it.
  always @(negedge clock) begin
    if (!ref_loaded) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = initWord(i);
      ref_loaded = 1'b1;
    end
    if (reset) begin
      sopc_q.delete(); sopc_cyc.delete(); tr_q.delete(); tr_cyc.delete();
    end else begin
      if (!sopc_waitrequest && !tr_waitrequest) checkOutput("dual_grant", 1, 0);
      if (!sopc_waitrequest) begin
        if (log_en) begin grant_who.push_back(0); grant_cyc.push_back(cycle); end
        if (sopc_write)
          ref_mem[sopc_address[7:0]] = mergeWrite(ref_mem[sopc_address[7:0]], sopc_writedata, sopc_byteenable);
        else begin
          sopc_q.push_back(ref_mem[sopc_address[7:0]]);
          sopc_cyc.push_back(cycle);
        end
      end
      if (!tr_waitrequest) begin
        if (log_en) begin grant_who.push_back(1); grant_cyc.push_back(cycle); end
        if (tr_write)
          ref_mem[tr_address[7:0]] = mergeWrite(ref_mem[tr_address[7:0]], tr_writedata, tr_byteenable);
        else begin
          tr_q.push_back(ref_mem[tr_address[7:0]]);
          tr_cyc.push_back(cycle);
        end
      end
      if (sopc_readdataready) begin
        if (sopc_q.size() == 0) checkOutput("sopc_spurious_rdy", 1, 0);
        else begin
          checkOutput("sopc_rdata", 32'(sopc_readdata), 32'(sopc_q.pop_front()));
          checkOutput("sopc_rd_latency", cycle - sopc_cyc.pop_front(), 3);
        end
      end
      if (tr_readdataready) begin
        if (tr_q.size() == 0) checkOutput("tr_spurious_rdy", 1, 0);
        else begin
          checkOutput("tr_rdata", 32'(tr_readdata), 32'(tr_q.pop_front()));
          checkOutput("tr_rd_latency", cycle - tr_cyc.pop_front(), 3);
        end
      end
    end
  end

  task automatic clearRequests();
    sopc_read = 0; sopc_write = 0; tr_read = 0; tr_write = 0;
  endtask

  // Drives one request from posedge+1 and holds it until the acceptance cycle.
  task automatic applyStimulus(input bit to_tr, input bit rd, input bit wr, input logic [19:0] addr,
                               input logic [1:0] be, input logic [15:0] data);
    bit got = 0;
    if (to_tr) begin
      tr_read = rd; tr_write = wr; tr_address = addr; tr_byteenable = be; tr_writedata = data;
    end else begin
      sopc_read = rd; sopc_write = wr; sopc_address = addr; sopc_byteenable = be; sopc_writedata = data;
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (to_tr ? !tr_waitrequest : !sopc_waitrequest) begin got = 1; break; end
    end
    checkOutput(to_tr ? "tr_accept" : "sopc_accept", 32'(got), 1);
    @(posedge clock); #1;
    if (to_tr) begin tr_read = 0; tr_write = 0; end
    else begin sopc_read = 0; sopc_write = 0; end
  endtask

  task automatic waitIdle();
    bit idle = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (!busy) begin idle = 1; break; end
    end
    checkOutput("idle_reached", 32'(idle), 1);
    @(posedge clock); #1;
  endtask

  task automatic waitGrants(input int n);
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      if (grant_who.size() >= n) break;
    end
    @(posedge clock); #1;
    clearRequests();
    log_en = 0;
  endtask

  task automatic checkGrantLog(input string tag);
    checkOutput({tag, "_count"}, grant_who.size(), exp_grant.size());
    for (int i = 0; i < exp_grant.size() && i < grant_who.size(); i++) begin
      checkOutput({tag, "_who"}, grant_who[i], exp_grant[i]);
      if (i > 0) checkOutput({tag, "_interval"}, grant_cyc[i] - grant_cyc[i-1], 4);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rdy_seen;
    reset = 1; tr_priority = 0;
    clearRequests();
    sopc_address = 0; tr_address = 0; sopc_byteenable = 0; tr_byteenable = 0;
    sopc_writedata = 0; tr_writedata = 0;
    repeat (3) @(negedge clock);
    checkOutput("rst_ce_n", 32'(sram_ce_n), 1);
    checkOutput("rst_oe_n", 32'(sram_oe_n), 1);
    checkOutput("rst_we_n", 32'(sram_we_n), 1);
    checkOutput("rst_be_n", 32'(sram_be_n), 3);
    checkOutput("rst_addr", 32'(sram_address), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_rdata", {sopc_readdata, tr_readdata}, 0);
    checkOutput("rst_rdy", {sopc_readdataready, tr_readdataready}, 0);
    @(posedge clock); #1 reset = 0;

    $display("[TB] single sopc read");
    applyStimulus(0, 1, 0, 20'h00010, 2'b11, 16'h0);
    for (int t = 1; t <= 2; t++) begin
      @(negedge clock);
      checkOutput("rd_ce_n", 32'(sram_ce_n), 0);
      checkOutput("rd_oe_n", 32'(sram_oe_n), 0);
      checkOutput("rd_we_n", 32'(sram_we_n), 1);
      checkOutput("rd_addr", 32'(sram_address), 32'h10);
    end
    @(negedge clock);
    checkOutput("rd_recover_ce_n", 32'(sram_ce_n), 1);
    checkOutput("rd_rdy", 32'(sopc_readdataready), 1);
    checkOutput("rd_data", 32'(sopc_readdata), 32'hBEEF);
    checkOutput("rd_other_rdy", 32'(tr_readdataready), 0);
    checkOutput("rd_other_data", 32'(tr_readdata), 0);
    waitIdle();

    $display("[TB] single tr write, partial byte lanes");
    applyStimulus(1, 0, 1, 20'hFFFFF, 2'b01, 16'hA5A5);
    for (int t = 1; t <= 2; t++) begin
      @(negedge clock);
      checkOutput("wr_we_n", 32'(sram_we_n), 0);
      checkOutput("wr_oe_n", 32'(sram_oe_n), 1);
      checkOutput("wr_be_n", 32'(sram_be_n), 2);
      checkOutput("wr_data", 32'(sram_data), 32'hA5A5);
      checkOutput("wr_addr", 32'(sram_address), 32'hFFFFF);
    end
    @(negedge clock);
    checkOutput("wr_recover_we_n", 32'(sram_we_n), 1);
    checkOutput("wr_recover_be_n", 32'(sram_be_n), 3);
    checkOutput("wr_hold_data", 32'(sram_data), 32'hA5A5);
    checkOutput("wr_no_rdy", 32'(tr_readdataready), 0);
    waitIdle();
    applyStimulus(1, 1, 0, 20'hFFFFF, 2'b11, 16'h0);
    waitIdle();

    $display("[TB] round-robin contention");
    grant_who.delete(); grant_cyc.delete(); exp_grant.delete();
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(0); exp_grant.push_back(1);
    log_en = 1;
    sopc_address = 20'h00010; sopc_byteenable = 2'b11; sopc_read = 1;
    tr_address = 20'hFFFFF; tr_byteenable = 2'b11; tr_read = 1;
    waitGrants(4);
    waitIdle();
    checkGrantLog("rr");

    $display("[TB] read+write as write, late tr arrival");
    applyStimulus(0, 1, 1, 20'h00020, 2'b11, 16'h1234);
    tr_read = 1; tr_address = 20'h00020; tr_byteenable = 2'b11;
    @(negedge clock);
    checkOutput("rw_we_n", 32'(sram_we_n), 0);
    checkOutput("rw_oe_n", 32'(sram_oe_n), 1);
    checkOutput("late_wait_access1", 32'(tr_waitrequest), 1);
    @(negedge clock);
    checkOutput("late_wait_access2", 32'(tr_waitrequest), 1);
    @(negedge clock);
    checkOutput("late_wait_recover", 32'(tr_waitrequest), 1);
    checkOutput("rw_no_rdy", 32'(sopc_readdataready), 0);
    @(negedge clock);
    checkOutput("late_accept_idle", 32'(tr_waitrequest), 0);
    @(posedge clock); #1 tr_read = 0;
    waitIdle();

    $display("[TB] priority mode with starvation cap");
    tr_priority = 1;
    grant_who.delete(); grant_cyc.delete(); exp_grant.delete();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) exp_grant.push_back(1);
      exp_grant.push_back(0);
    end
    log_en = 1;
    sopc_address = 20'h00020; sopc_read = 1;
    tr_address = 20'h00010; tr_read = 1;
    waitGrants(10);
    waitIdle();
    tr_priority = 0;
    checkGrantLog("prio");

    $display("[TB] reset during second access cycle");
    applyStimulus(0, 1, 0, 20'h00010, 2'b11, 16'h0);
    @(posedge clock); #1 reset = 1;
    #1;
    checkOutput("mid_rst_ce_n", 32'(sram_ce_n), 1);
    checkOutput("mid_rst_oe_n", 32'(sram_oe_n), 1);
    checkOutput("mid_rst_be_n", 32'(sram_be_n), 3);
    checkOutput("mid_rst_busy", 32'(busy), 0);
    @(negedge clock);
    @(posedge clock); #1 reset = 0;
    rdy_seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (sopc_readdataready || tr_readdataready) rdy_seen++;
    end
    checkOutput("mid_rst_no_rdy", rdy_seen, 0);
    @(posedge clock); #1;
    applyStimulus(0, 1, 0, 20'h00010, 2'b11, 16'h0);
    waitIdle();
    repeat (2) @(negedge clock);

    checkOutput("sopc_sb_empty", sopc_q.size(), 0);
    checkOutput("tr_sb_empty", tr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
